// File: rtl/komandara_axil_pkg.sv
// Shared AXI4-Lite definitions for the komandara memory-to-AXI4-Lite bridge.
//
// Contents:
//   axi_resp_t / RESP_*   AXI response codes (OKAY, EXOKAY, SLVERR, DECERR)
//   AXI_PROT_DEFAULT      default value driven on awprot/arprot
//   bridge_state_e        bridge FSM states
//   resp_is_err()         1 when a response code reports an error
package komandara_axil_pkg;

  typedef logic [1:0] axi_resp_t;

  localparam axi_resp_t RESP_OKAY   = 2'b00;
  localparam axi_resp_t RESP_EXOKAY = 2'b01;
  localparam axi_resp_t RESP_SLVERR = 2'b10;
  localparam axi_resp_t RESP_DECERR = 2'b11;

  localparam logic [2:0] AXI_PROT_DEFAULT = 3'b000;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WR,
    ST_WR_RESP,
    ST_RD_ADDR,
    ST_RD_RESP
  } bridge_state_e;

  // SLVERR and DECERR are the two error codes; both have bit 1 set.
  function automatic logic resp_is_err(input axi_resp_t resp);
    return (resp == RESP_SLVERR) || (resp == RESP_DECERR);
  endfunction

endpackage

// File: rtl/komandara_mem2axil_bridge_if.sv
// AXI4-Lite bus bundle used between the bridge (master) and the downstream
// slave or interconnect (slave).
//
// Parameters:
//   ADDR_WIDTH  address width of AW/AR
//   DATA_WIDTH  data width of W/R (32 or 64); strobes are DATA_WIDTH/8
//
// Modports:
//   master  drives AW/W/AR payload+valid and bready/rready
//   slave   drives awready/wready/arready and the B/R responses
interface komandara_mem2axil_bridge_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  // Write address channel
  logic [ADDR_WIDTH-1:0] awaddr;
  logic [2:0]            awprot;
  logic                  awvalid;
  logic                  awready;

  // Write data channel
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wvalid;
  logic                  wready;

  // Write response channel
  logic [1:0]            bresp;
  logic                  bvalid;
  logic                  bready;

  // Read address channel
  logic [ADDR_WIDTH-1:0] araddr;
  logic [2:0]            arprot;
  logic                  arvalid;
  logic                  arready;

  // Read data channel
  logic [DATA_WIDTH-1:0] rdata;
  logic [1:0]            rresp;
  logic                  rvalid;
  logic                  rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );

endinterface

// File: rtl/komandara_mem2axil_bridge.sv
// Converts the core's request/grant load-store port into AXI4-Lite master
// transactions, one transaction outstanding at a time. Each transaction
// finishes with a single-cycle o_rvalid pulse carrying read data (zero for
// writes) and an error flag (SLVERR/DECERR).
//
// Parameters:
//   ADDR_WIDTH  core/AXI address width
//   DATA_WIDTH  data width, 32 or 64
//   AXI_PROT    constant driven on awprot/arprot
//
// Ports:
//   i_clk, i_rst_n         clock, asynchronous active-low reset
//   i_req, o_gnt           core request / combinational grant
//   i_we, i_addr, i_wdata, i_be   request payload (be -> wstrb)
//   o_rvalid, o_rdata, o_err      registered completion pulse and result
//   m_axi                  AXI4-Lite master bundle
module komandara_mem2axil_bridge
  import komandara_axil_pkg::*;
#(
  parameter int         ADDR_WIDTH = 32,
  parameter int         DATA_WIDTH = 32,
  parameter logic [2:0] AXI_PROT   = AXI_PROT_DEFAULT
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,

  input  logic                    i_req,
  output logic                    o_gnt,
  input  logic                    i_we,
  input  logic [ADDR_WIDTH-1:0]   i_addr,
  input  logic [DATA_WIDTH-1:0]   i_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_be,
  output logic                    o_rvalid,
  output logic [DATA_WIDTH-1:0]   o_rdata,
  output logic                    o_err,

  komandara_mem2axil_bridge_if.master m_axi
);

  bridge_state_e           state_q;

  // Request payload captured on the grant; drives the AXI payload fields
  // so they stay stable for the whole transaction.
  logic [ADDR_WIDTH-1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [DATA_WIDTH/8-1:0] be_q;
  logic                    we_q;

  logic                    awvalid_q;
  logic                    wvalid_q;
  logic                    arvalid_q;
  logic                    bready_q;
  logic                    rready_q;

  // Write channels still waiting after the coming edge. The FSM leaves
  // ST_WR only when neither AW nor W remains outstanding, which covers
  // both handshakes landing together or in either order.
  logic                    aw_busy;
  logic                    w_busy;

  // Completion of the current transaction (B or R handshake this cycle).
  logic                    cpl_fire;
  axi_resp_t               cpl_resp;
  logic [DATA_WIDTH-1:0]   cpl_data;

  assign o_gnt    = (state_q == ST_IDLE) && i_req;

  assign aw_busy  = awvalid_q && !m_axi.awready;
  assign w_busy   = wvalid_q  && !m_axi.wready;

  assign cpl_fire = ((state_q == ST_WR_RESP) && m_axi.bvalid) ||
                    ((state_q == ST_RD_RESP) && m_axi.rvalid);
  assign cpl_resp = we_q ? m_axi.bresp : m_axi.rresp;
  assign cpl_data = we_q ? '0 : m_axi.rdata;

  assign m_axi.awaddr  = addr_q;
  assign m_axi.awprot  = AXI_PROT;
  assign m_axi.awvalid = awvalid_q;
  assign m_axi.wdata   = wdata_q;
  assign m_axi.wstrb   = be_q;
  assign m_axi.wvalid  = wvalid_q;
  assign m_axi.bready  = bready_q;
  assign m_axi.araddr  = addr_q;
  assign m_axi.arprot  = AXI_PROT;
  assign m_axi.arvalid = arvalid_q;
  assign m_axi.rready  = rready_q;

  // NOTE: every register here uses non-blocking assignments so all state
  // updates see the pre-edge values, independent of statement order. The
  // payload registers are reset too, so the bus never shows X after reset.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q   <= ST_IDLE;
      addr_q    <= '0;
      wdata_q   <= '0;
      be_q      <= '0;
      we_q      <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q  <= 1'b0;
      arvalid_q <= 1'b0;
      bready_q  <= 1'b0;
      rready_q  <= 1'b0;
      o_rvalid  <= 1'b0;
      o_rdata   <= '0;
      o_err     <= 1'b0;
    end else begin
      o_rvalid <= 1'b0;

      // o_rdata/o_err hold their value between completions.
      if (cpl_fire) begin
        o_rvalid <= 1'b1;
        o_rdata  <= cpl_data;
        o_err    <= resp_is_err(cpl_resp);
      end

      unique case (state_q)
        ST_IDLE: begin
          if (i_req) begin
            addr_q  <= i_addr;
            wdata_q <= i_wdata;
            be_q    <= i_be;
            we_q    <= i_we;
            if (i_we) begin
              awvalid_q <= 1'b1;
              wvalid_q  <= 1'b1;
              state_q   <= ST_WR;
            end else begin
              arvalid_q <= 1'b1;
              state_q   <= ST_RD_ADDR;
            end
          end
        end

        ST_WR: begin
          // Each valid drops only after its own handshake.
          if (m_axi.awready) awvalid_q <= 1'b0;
          if (m_axi.wready)  wvalid_q  <= 1'b0;
          if (!aw_busy && !w_busy) begin
            bready_q <= 1'b1;
            state_q  <= ST_WR_RESP;
          end
        end

        ST_WR_RESP: begin
          if (m_axi.bvalid) begin
            bready_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end

        ST_RD_ADDR: begin
          if (m_axi.arready) begin
            arvalid_q <= 1'b0;
            rready_q  <= 1'b1;
            state_q   <= ST_RD_RESP;
          end
        end

        ST_RD_RESP: begin
          if (m_axi.rvalid) begin
            rready_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end

        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule
